// File: rtl/trivium_keystream.sv
// trivium_keystream: Trivium keystream generator (80-bit key, 80-bit IV, 288-bit state).
// Loads KEY/IV on the first edge after reset, runs INIT_ROUNDS warm-up rounds,
// then shifts len keystream bits into OUT (newest bit at OUT[0]) and freezes.
// Optional macro ENCRIPT_DONE_EN adds a sticky 'done' output after OUT.
module trivium_keystream #(
    parameter int OUT_W       = 4096,
    parameter int INIT_ROUNDS = 1152
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [79:0]      KEY,
    input  logic [79:0]      IV,
    input  logic [15:0]      len,
    output logic [OUT_W-1:0] OUT
`ifdef ENCRIPT_DONE_EN
    ,
    output logic             done
`endif
);

    localparam int LEN_W  = $clog2(OUT_W + 1);
    localparam int INIT_W = $clog2(INIT_ROUNDS);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        INIT = 2'd1,
        GEN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [287:0]        s_reg, s_next;
    logic [OUT_W-1:0]    out_reg, out_next;
    logic [INIT_W-1:0]   init_cnt_reg, init_cnt_next;
    logic [LEN_W-1:0]    gen_cnt_reg, gen_cnt_next;
    logic [LEN_W-1:0]    len_q_reg, len_q_next;
    logic                done_reg, done_next;

    // Bit s_i of the cipher state lives at s_reg[i-1].
    logic [287:0]        load_vec;
    logic [287:0]        round_vec;
    logic                t1, t2, t3, z, u1, u2, u3;
    logic [LEN_W-1:0]    len_clamped;

    // Key fills s1..s80 and IV fills s94..s173, both MSB first.
    genvar gi;
    generate
        for (gi = 0; gi < 80; gi++) begin : g_load
            assign load_vec[gi]      = KEY[79-gi];
            assign load_vec[93 + gi] = IV[79-gi];
        end
    endgenerate
    assign load_vec[92:80]   = '0;
    assign load_vec[284:173] = '0;
    assign load_vec[287:285] = 3'b111;

    assign len_clamped = (len > 16'(OUT_W)) ? LEN_W'(OUT_W) : len[LEN_W-1:0];

    // One Trivium round, purely from the current state.
    assign t1 = s_reg[65]  ^ s_reg[92];
    assign t2 = s_reg[161] ^ s_reg[176];
    assign t3 = s_reg[242] ^ s_reg[287];
    assign z  = t1 ^ t2 ^ t3;
    assign u1 = t1 ^ (s_reg[90]  & s_reg[91])  ^ s_reg[170];
    assign u2 = t2 ^ (s_reg[174] & s_reg[175]) ^ s_reg[263];
    assign u3 = t3 ^ (s_reg[285] & s_reg[286]) ^ s_reg[68];
    assign round_vec = {s_reg[286:177], u2, s_reg[175:93], u1, s_reg[91:0], u3};

    // Next-state logic: load, warm-up, keystream collection, then hold.
    always_comb begin
        state_next    = state_reg;
        s_next        = s_reg;
        out_next      = out_reg;
        init_cnt_next = init_cnt_reg;
        gen_cnt_next  = gen_cnt_reg;
        len_q_next    = len_q_reg;
        done_next     = done_reg;
        case (state_reg)
            LOAD: begin
                s_next     = load_vec;
                len_q_next = len_clamped;
                state_next = INIT;
            end
            INIT: begin
                s_next        = round_vec;
                init_cnt_next = init_cnt_reg + INIT_W'(1);
                if (init_cnt_reg == INIT_W'(INIT_ROUNDS - 1)) begin
                    if (len_q_reg != '0) begin
                        state_next = GEN;
                    end else begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end
            end
            GEN: begin
                s_next       = round_vec;
                out_next     = {out_reg[OUT_W-2:0], z};
                gen_cnt_next = gen_cnt_reg + LEN_W'(1);
                if (gen_cnt_reg == len_q_reg - LEN_W'(1)) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = DONE;
            end
        endcase
    end

    // State registers; reset clears everything at once, even mid-run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= LOAD;
            s_reg        <= '0;
            out_reg      <= '0;
            init_cnt_reg <= '0;
            gen_cnt_reg  <= '0;
            len_q_reg    <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            s_reg        <= s_next;
            out_reg      <= out_next;
            init_cnt_reg <= init_cnt_next;
            gen_cnt_reg  <= gen_cnt_next;
            len_q_reg    <= len_q_next;
            done_reg     <= done_next;
        end
    end

    assign OUT = out_reg;
`ifdef ENCRIPT_DONE_EN
    assign done = done_reg;
`endif

endmodule

// File: tb/tb_trivium_keystream.sv
// Testbench for trivium_keystream: random key/IV/len runs checked against a
// bit-level Trivium model. Covers ENCRIPT_DONE_EN checks when that macro is set.
module tb_trivium_keystream;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [79:0]   KEY = '0;
    logic [79:0]   IV = '0;
    logic [15:0]   len = '0;
    logic [4095:0] OUT;
`ifdef ENCRIPT_DONE_EN
    logic          done;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trivium_keystream dut (
        .clk   (clk),
        .reset (reset),
        .KEY   (KEY),
        .IV    (IV),
        .len   (len),
        .OUT   (OUT)
`ifdef ENCRIPT_DONE_EN
        ,
        .done  (done)
`endif
    );

    // Reference: s[1..288] loaded from key/IV, 1152 warm-up rounds, then n
    // keystream bits; the first bit lands at index n-1, the last at index 0.
    function automatic logic [4095:0] model_out(input logic [79:0] k, input logic [79:0] v, input int n);
        bit s [1:288];
        logic [4095:0] res;
        bit t1, t2, t3, z, u1, u2, u3;
        res = '0;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[80-i];
            s[93 + i] = v[80-i];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int r = 0; r < 1152 + n; r++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            u1 = t1 ^ (s[91] & s[92]) ^ s[171];
            u2 = t2 ^ (s[175] & s[176]) ^ s[264];
            u3 = t3 ^ (s[286] & s[287]) ^ s[69];
            if (r >= 1152) res[n - 1 - (r - 1152)] = z;
            for (int i = 93; i >= 2; i--) s[i] = s[i-1];
            s[1] = u3;
            for (int i = 177; i >= 95; i--) s[i] = s[i-1];
            s[94] = u1;
            for (int i = 288; i >= 179; i--) s[i] = s[i-1];
            s[178] = u2;
        end
        return res;
    endfunction

    function automatic int first_diff(input logic [4095:0] a, input logic [4095:0] b);
        for (int i = 0; i < 4096; i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    function automatic logic [79:0] rand80();
        logic [95:0] tmp;
        tmp = {$urandom(), $urandom(), $urandom()};
        return tmp[79:0];
    endfunction

    // Reset for one cycle with the given inputs; returns at the negedge of release.
    task automatic start_run(input logic [79:0] k, input logic [79:0] v, input logic [15:0] l);
        @(negedge clk);
        reset = 1'b1;
        KEY = k; IV = v; len = l;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        KEY = rand80(); IV = rand80(); len = 16'd100;
        run_edges(3);
        checks++;
        if (OUT !== '0) begin
            errors++;
            $display("FAIL reset_out: got low64=%h required 0 (first set bit %0d)", OUT[63:0], first_diff(OUT, '0));
        end
`ifdef ENCRIPT_DONE_EN
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
`endif
        $display("test_reset: done");
    endtask

    task automatic test_key_msb();
        logic [79:0]   k;
        logic [4095:0] exp, exp1;
        k = 80'h8000_0000_0000_0000_0000;
        exp  = model_out(k, '0, 4096);
        exp1 = model_out(k, '0, 1);
        start_run(k, '0, 16'd4096);
        run_edges(1153);
        checks++;
        if (OUT !== '0) begin
            errors++;
            $display("FAIL msb_pre_gen: got low64=%h required 0", OUT[63:0]);
        end
        run_edges(1);
        checks++;
        if (OUT !== exp1) begin
            errors++;
            $display("FAIL msb_first_bit: got low64=%h required %h", OUT[63:0], exp1[63:0]);
        end
        run_edges(4094);
`ifdef ENCRIPT_DONE_EN
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL msb_done_early: got %b required 0", done); end
`endif
        run_edges(1);
        checks++;
        if (OUT !== exp) begin
            errors++;
            $display("FAIL msb_full: first diff bit %0d got top64=%h required %h", first_diff(OUT, exp), OUT[4095:4032], exp[4095:4032]);
        end
`ifdef ENCRIPT_DONE_EN
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL msb_done: got %b required 1", done); end
`endif
        run_edges(1000);
        checks++;
        if (OUT !== exp) begin
            errors++;
            $display("FAIL msb_frozen: first diff bit %0d", first_diff(OUT, exp));
        end
        $display("test_key_msb: done");
    endtask

    task automatic test_short_len();
        logic [4095:0] exp, exp1;
        exp  = model_out('0, '0, 8);
        exp1 = model_out('0, '0, 1);
        start_run('0, '0, 16'd8);
        run_edges(1153 + 8);
        checks++;
        if (OUT[4095:8] !== '0) begin
            errors++;
            $display("FAIL short_upper_zero: first set bit %0d", first_diff(OUT, '0));
        end
        checks++;
        if (OUT[7] !== exp1[0]) begin
            errors++;
            $display("FAIL short_first_bit: got %b required %b", OUT[7], exp1[0]);
        end
        checks++;
        if (OUT[7:0] !== exp[7:0]) begin
            errors++;
            $display("FAIL short_byte: got %b required %b", OUT[7:0], exp[7:0]);
        end
        run_edges(20);
        checks++;
        if (OUT !== exp) begin
            errors++;
            $display("FAIL short_frozen: got low64=%h required %h", OUT[63:0], exp[63:0]);
        end
        $display("test_short_len: done");
    endtask

    task automatic test_len_zero();
        start_run(rand80(), rand80(), 16'd0);
        run_edges(1152);
`ifdef ENCRIPT_DONE_EN
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %b required 0", done); end
`endif
        run_edges(1);
`ifdef ENCRIPT_DONE_EN
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b required 1", done); end
`endif
        checks++;
        if (OUT !== '0) begin errors++; $display("FAIL zero_out_1153: got low64=%h required 0", OUT[63:0]); end
        run_edges(300);
        checks++;
        if (OUT !== '0) begin errors++; $display("FAIL zero_out_later: got low64=%h required 0", OUT[63:0]); end
        $display("test_len_zero: done");
    endtask

    task automatic test_clamp();
        logic [79:0]   k, v;
        logic [4095:0] exp;
        k = rand80(); v = rand80();
        exp = model_out(k, v, 4096);
        start_run(k, v, 16'hFFFF);
        run_edges(1153 + 4096);
        checks++;
        if (OUT !== exp) begin
            errors++;
            $display("FAIL clamp_full: first diff bit %0d got low64=%h required %h", first_diff(OUT, exp), OUT[63:0], exp[63:0]);
        end
        run_edges(50);
        checks++;
        if (OUT !== exp) begin errors++; $display("FAIL clamp_frozen: first diff bit %0d", first_diff(OUT, exp)); end
        $display("test_clamp: done");
    endtask

    task automatic test_mid_reset();
        logic [79:0]   k1, k2, v;
        logic [15:0]   l2;
        logic [4095:0] exp;
        k1 = rand80(); k2 = rand80(); v = rand80();
        l2 = 16'($urandom_range(100, 700));
        exp = model_out(k1, v, 600);
        start_run(k1, v, 16'd4096);
        run_edges(1153 + 600);
        checks++;
        if (OUT !== exp) begin
            errors++;
            $display("FAIL midrst_partial: first diff bit %0d got low64=%h required %h", first_diff(OUT, exp), OUT[63:0], exp[63:0]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (OUT !== '0) begin errors++; $display("FAIL midrst_async_clear: got low64=%h required 0", OUT[63:0]); end
        KEY = k2; len = l2;
        @(negedge clk);
        reset = 1'b0;
        exp = model_out(k2, v, int'(l2));
        run_edges(1153 + int'(l2));
        checks++;
        if (OUT !== exp) begin
            errors++;
            $display("FAIL midrst_rerun: len %0d first diff bit %0d got low64=%h required %h", l2, first_diff(OUT, exp), OUT[63:0], exp[63:0]);
        end
        $display("test_mid_reset: done");
    endtask

    task automatic test_input_change();
        logic [79:0]   k, v;
        logic [15:0]   l;
        logic [4095:0] exp;
        k = rand80(); v = rand80();
        l = 16'($urandom_range(50, 400));
        exp = model_out(k, v, int'(l));
        start_run(k, v, l);
        run_edges(500);
        KEY = rand80(); IV = rand80(); len = 16'($urandom_range(401, 4096));
        run_edges(1153 + int'(l) - 500);
        checks++;
        if (OUT !== exp) begin
            errors++;
            $display("FAIL inchange_out: len %0d first diff bit %0d got low64=%h required %h", l, first_diff(OUT, exp), OUT[63:0], exp[63:0]);
        end
        run_edges(10);
        checks++;
        if (OUT !== exp) begin errors++; $display("FAIL inchange_frozen: first diff bit %0d", first_diff(OUT, exp)); end
        $display("test_input_change: done");
    endtask

    task automatic test_random_runs();
        logic [79:0]   k, v;
        int            l;
        logic [4095:0] exp, exp_part;
        for (int r = 0; r < 4; r++) begin
            k = rand80(); v = rand80();
            l = int'($urandom_range(1, 256));
            exp      = model_out(k, v, l);
            exp_part = model_out(k, v, l - 1);
            start_run(k, v, 16'(l));
            run_edges(1153 + l - 1);
            checks++;
            if (OUT !== exp_part) begin
                errors++;
                $display("FAIL rand%0d_partial: len %0d got low64=%h required %h", r, l, OUT[63:0], exp_part[63:0]);
            end
`ifdef ENCRIPT_DONE_EN
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL rand%0d_done_early: got %b required 0", r, done); end
`endif
            run_edges(1);
            checks++;
            if (OUT !== exp) begin
                errors++;
                $display("FAIL rand%0d_full: len %0d first diff bit %0d got low64=%h required %h", r, l, first_diff(OUT, exp), OUT[63:0], exp[63:0]);
            end
`ifdef ENCRIPT_DONE_EN
            checks++;
            if (done !== 1'b1) begin errors++; $display("FAIL rand%0d_done: got %b required 1", r, done); end
`endif
            $display("test_random_runs: run %0d len %0d done", r, l);
        end
    endtask

    initial begin
        test_reset();
        test_key_msb();
        test_short_len();
        test_len_zero();
        test_clamp();
        test_mid_reset();
        test_input_change();
        test_random_runs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
